multicycle_controlunit: RTL
===========================

# multicycle_controlunit

Multi-cycle control FSM for the RV32I datapath, replacing the single-cycle combinational decoder so instruction and data memories may have variable latency. It sequences each instruction through fetch/decode/execute/memory/writeback states and emits per-cycle datapath strobes. It adds an optional multiply/divide handshake, full branch-condition decode, illegal-instruction trapping and a data-memory timeout.

## Interface
- ENABLE_M, 1, 1 = R-type with funct7b0=1 runs on the external mul/div unit; 0 = such encodings are illegal
- TRAP_ON_ILLEGAL, 1, 1 = illegal instruction enters TRAP; 0 = treated as NOP (PC+4, retired)
- MEM_TIMEOUT, 0, 0 = no timeout; N>0 = trap if mem_ready absent for N cycles in MEM

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- opcode  in  7  instruction[6:0], from IR
- funct3  in  3  instruction[14:12]
- funct7  in  1  instruction[30]
- funct7b0  in  1  instruction[25]
- eq, lt, ltu  in  1 each  ALU compare flags for branches
- imem_ready  in  1  instruction-fetch data valid
- mem_ready  in  1  data access complete
- mul_done  in  1  mul/div result valid
- imem_req  out  1  instruction fetch request
- irwrite  out  1  latch IR
- pcwrite  out  1  update PC
- pcsrc  out  1  0 = PC+4, 1 = target
- jbmux  out  1  1 = target from ALU (jalr)
- regwrite, alusrc, memread, memwrite, pcwritemux  out  1 each
- resultsrc  out  2  0 ALU, 1 load data, 2 mul/div result
- aluctrl  out  4
- immsrc, addrmode  out  3 each
- mul_start  out  1  one-cycle start pulse
- illegal  out  1  high while in TRAP
- retire  out  1  one-cycle pulse per completed instruction
- state  out  3  current state (debug)

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MUL=5, TRAP=6.
- FETCH: imem_req=1. On imem_ready: irwrite=1, go to DECODE.
- DECODE: legality check. Legal opcodes: 0x03, 0x13, 0x23, 0x33, 0x63, 0x67, 0x6F. funct3 2/3 with 0x63 is illegal. funct7b0 with 0x33 and ENABLE_M=0 is illegal. Illegal goes to TRAP, or to FETCH with pcwrite=1, pcsrc=0, retire=1 when TRAP_ON_ILLEGAL=0. Otherwise go to EXEC.
- EXEC by opcode:
  - 0x63: pcwrite=1, pcsrc=taken, retire=1, go to FETCH. taken by funct3: 0 eq, 1 !eq, 4 lt, 5 !lt, 6 ltu, 7 !ltu.
  - 0x03/0x23: go to MEM.
  - 0x33 with funct7b0 and ENABLE_M: mul_start=1, go to MUL.
  - All others: go to WB.
- MEM: memread (load) or memwrite (store) held until mem_ready. Load goes to WB. Store gets pcwrite=1, retire=1, then FETCH.
- MUL: wait for mul_done, then go to WB.
- WB: regwrite=1, pcwrite=1, retire=1, then FETCH.
  - pcwritemux=1 for 0x67/0x6F.
  - pcsrc=1 for jumps.
  - jbmux=1 for 0x67.
  - resultsrc=1 for load, 2 for mul/div.
- TRAP: illegal=1, all other strobes 0. Exited only by rst.
- Static decode, valid DECODE..WB:
  - alusrc as single-cycle unit: 0x03/0x13/0x23/0x67.
  - immsrc: I=0, S=2, B=3, R=7, J/other=4.
  - addrmode=funct3.
  - aluctrl: load/store/jump = 0x0; branch = 0x8 (sub); R = {funct7,funct3} for funct3 0/5, else {0,funct3}; I = {funct7,5} for funct3 5, else {0,funct3}.
- Timeout counter: width clog2(MEM_TIMEOUT+1). Cleared on entering MEM, increments each MEM cycle without mem_ready. Reaching MEM_TIMEOUT enters TRAP with memread/memwrite dropped.
- Outputs are Moore functions of state plus current fields. All strobes are 0 outside the states listed.

## Timing
- rst has priority over everything. While rst=1 all outputs are 0 and state is 0. Next state after reset release is FETCH.
- rst mid-instruction aborts it: no retire, no pcwrite, counter cleared.
- Minimum latency with zero-wait memories:
  - Branch: 3 cycles (FETCH, DECODE, EXEC).
  - ALU/jump: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Mul/div: 5 cycles plus mul_done wait.
- Each wait cycle in FETCH/MEM/MUL adds exactly 1 cycle.
- mem_ready and mul_done arriving in the same cycle the state is entered complete that state in 1 cycle.
- Inputs outside the awaited state are ignored.
- mul_start is asserted exactly 1 cycle per mul/div instruction.

## Test plan
- Reset, then opcode 0x13 funct3 0 with imem_ready=1 and mem_ready=1: state sequence 0,1,2,4,0. regwrite=1 only in WB. retire=1 once. aluctrl=0x0, immsrc=0.
- Load 0x03 with mem_ready delayed 3 cycles: memread high 4 cycles. WB has resultsrc=1. Total 8 cycles.
- Branches, funct3 0..7 × eq/lt/ltu sweep:
  - pcsrc matches the truth table in EXEC; retire after 3 cycles.
  - funct3 2/3 → illegal=1 in the next cycle, held until rst.
- ENABLE_M=1, 0x33 with funct7b0=1 and mul_done after 2 cycles: single mul_start pulse, resultsrc=2 in WB. Same instruction with ENABLE_M=0 and TRAP_ON_ILLEGAL=0: pcwrite with pcsrc=0, retire, no regwrite.
- MEM_TIMEOUT=4, store with mem_ready never asserted: memwrite high 4 cycles, then TRAP, memwrite=0. rst=1 for 1 cycle returns to FETCH with all outputs 0.

Source files
------------

// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives per-cycle datapath strobes, with optional mul/div handshake and memory timeout.
//
// state  | meaning
// FETCH  | request instruction, latch IR on imem_ready
// DECODE | legality check
// EXEC   | branch resolve / route to MEM, MUL or WB
// MEM    | data access until mem_ready or timeout
// WB     | register write, PC update, retire
// MUL    | wait for mul_done
// TRAP   | illegal instruction or memory timeout, left only by rst
module multicycle_controlunit #(
    parameter bit ENABLE_M        = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1,
    parameter int MEM_TIMEOUT     = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       funct7b0,
    input  logic       eq,
    input  logic       lt,
    input  logic       ltu,
    input  logic       imem_ready,
    input  logic       mem_ready,
    input  logic       mul_done,
    output logic       imem_req,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       pcsrc,
    output logic       jbmux,
    output logic       regwrite,
    output logic       alusrc,
    output logic       memread,
    output logic       memwrite,
    output logic       pcwritemux,
    output logic [1:0] resultsrc,
    output logic [3:0] aluctrl,
    output logic [2:0] immsrc,
    output logic [2:0] addrmode,
    output logic       mul_start,
    output logic       illegal,
    output logic       retire,
    output logic [2:0] state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_MUL    = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO_LOAD = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] to_cnt;
    logic          to_hit;
    logic          is_load, is_alui, is_store, is_r, is_br, is_jalr, is_jal;
    logic          is_mul, legal, taken;

    assign is_load  = (opcode == 7'h03);
    assign is_alui  = (opcode == 7'h13);
    assign is_store = (opcode == 7'h23);
    assign is_r     = (opcode == 7'h33);
    assign is_br    = (opcode == 7'h63);
    assign is_jalr  = (opcode == 7'h67);
    assign is_jal   = (opcode == 7'h6F);
    assign is_mul   = is_r && funct7b0 && ENABLE_M;
    assign legal    = (is_load || is_alui || is_store || is_r || is_br || is_jalr || is_jal)
                      && !(is_br && (funct3[2:1] == 2'b01))
                      && !(is_r && funct7b0 && !ENABLE_M);

    always_comb begin
        case (funct3)
            3'd0:    taken = eq;
            3'd1:    taken = !eq;
            3'd4:    taken = lt;
            3'd5:    taken = !lt;
            3'd6:    taken = ltu;
            3'd7:    taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    // Down-counter: reloaded on MEM entry, terminal count at zero with no mem_ready.
    assign to_hit = (MEM_TIMEOUT > 0) && (to_cnt == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (!legal) state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
                else        state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_br)                     state_d = S_FETCH;
                else if (is_load || is_store)  state_d = S_MEM;
                else if (is_mul)               state_d = S_MUL;
                else                           state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready)   state_d = is_load ? S_WB : S_FETCH;
                else if (to_hit) state_d = S_TRAP;
            end
            S_MUL:    if (mul_done) state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            to_cnt  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_EXEC && state_d == S_MEM)
                to_cnt <= TO_LOAD;
            else if (state_q == S_MEM && !mem_ready && to_cnt != '0)
                to_cnt <= to_cnt - 1'b1;
        end
    end

    always_comb begin
        imem_req   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = 1'b0;
        jbmux      = 1'b0;
        regwrite   = 1'b0;
        alusrc     = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        pcwritemux = 1'b0;
        resultsrc  = 2'd0;
        aluctrl    = 4'h0;
        immsrc     = 3'd0;
        addrmode   = 3'd0;
        mul_start  = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;
        state      = 3'd0;
        if (!rst) begin
            state = state_q;
            // Static decode is only meaningful while an instruction is in flight.
            if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
                alusrc   = is_load || is_alui || is_store || is_jalr;
                addrmode = funct3;
                if (is_load || is_alui || is_jalr) immsrc = 3'd0;
                else if (is_store)                 immsrc = 3'd2;
                else if (is_br)                    immsrc = 3'd3;
                else if (is_r)                     immsrc = 3'd7;
                else                               immsrc = 3'd4;
                if (is_br)
                    aluctrl = 4'h8;
                else if (is_r)
                    aluctrl = (funct3 == 3'd0 || funct3 == 3'd5) ? {funct7, funct3} : {1'b0, funct3};
                else if (is_alui)
                    aluctrl = (funct3 == 3'd5) ? {funct7, 3'd5} : {1'b0, funct3};
            end
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    irwrite  = imem_ready;
                end
                S_DECODE: begin
                    if (!legal && !TRAP_ON_ILLEGAL) begin
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                    end
                end
                S_EXEC: begin
                    if (is_br) begin
                        pcwrite = 1'b1;
                        pcsrc   = taken;
                        retire  = 1'b1;
                    end
                    mul_start = is_mul;
                end
                S_MEM: begin
                    memread  = is_load;
                    memwrite = is_store;
                    if (mem_ready && is_store) begin
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                    end
                end
                S_WB: begin
                    regwrite   = 1'b1;
                    pcwrite    = 1'b1;
                    retire     = 1'b1;
                    pcwritemux = is_jal || is_jalr;
                    pcsrc      = is_jal || is_jalr;
                    jbmux      = is_jalr;
                    resultsrc  = is_load ? 2'd1 : (is_mul ? 2'd2 : 2'd0);
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
